// File: rtl/acc_cpu_pkg.sv
// Shared constants for the accumulator CPU: opcode encodings, opcode field
// width and the 4-bit state encoding exported on StateNo.
package acc_cpu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OP_W-1:0] OP_STORE = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OP_W-1:0] OP_INPUT = 3'b100;
  localparam logic [OP_W-1:0] OP_JZ    = 3'b101;
  localparam logic [OP_W-1:0] OP_JPOS  = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT  = 3'b111;

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd3,
    S_STORE  = 4'd4,
    S_ADD    = 4'd5,
    S_SUB    = 4'd6,
    S_INPUT  = 4'd7,
    S_JZ     = 4'd8,
    S_JPOS   = 4'd9,
    S_HALT   = 4'd10
  } state_e;

endpackage

// File: rtl/acc_mem.sv
// Word memory for the accumulator CPU: asynchronous read, one synchronous
// write port. Contents are deliberately not reset.
module acc_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: control FSM + datapath around acc_mem.
// Optional sticky signed-overflow output enabled by macro ACC_OVF_FLAG_EN.
module acc_cpu_param
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step_en,
  input  logic              run,
  input  logic              enter,
  input  logic [DATA_W-1:0] Nin,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] Nout,
  output logic              Aeq0,
  output logic              Apos,
  output logic              halt,
  output logic [3:0]        StateNo,
`ifdef ACC_OVF_FLAG_EN
  output logic              ovf,
`endif
  output logic [ADDR_W-1:0] pc
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OP_W-1:0]   ir_op_q, ir_op_d;
  logic [ADDR_W-1:0] ir_addr_q, ir_addr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] nout_q, nout_d;
  logic              enter_q;
  logic              pend_q, pend_d;
  logic              clr_pend;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_wdata, mem_rd;
  logic [DATA_W-1:0] add_res, sub_res;
  logic              unused_mid;

  // Instruction bits between the opcode and the address field carry nothing.
  assign unused_mid = ^mem_rd;

  assign add_res = a_q + mem_rd;
  assign sub_res = a_q - mem_rd;

`ifdef ACC_OVF_FLAG_EN
  logic ovf_q, ovf_d;
  logic add_ovf, sub_ovf;
  assign add_ovf = (a_q[DATA_W-1] == mem_rd[DATA_W-1]) && (add_res[DATA_W-1] != a_q[DATA_W-1]);
  assign sub_ovf = (a_q[DATA_W-1] != mem_rd[DATA_W-1]) && (sub_res[DATA_W-1] != a_q[DATA_W-1]);
  assign ovf     = ovf_q;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_op_d   = ir_op_q;
    ir_addr_d = ir_addr_q;
    a_d       = a_q;
    nout_d    = nout_q;
    clr_pend  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = load_addr;
    mem_wdata = load_data;
    mem_raddr = (state_q == S_FETCH) ? pc_q : ir_addr_q;
`ifdef ACC_OVF_FLAG_EN
    ovf_d     = ovf_q;
`endif

    // Program loading is only allowed while the core is parked.
    if (load_en && (state_q == S_START || state_q == S_HALT)) mem_we = 1'b1;

    if (step_en) begin
      nout_d = a_q;
      case (state_q)
        S_START, S_HALT: begin
          if (run) begin
            pc_d    = '0;
            a_d     = '0;
            state_d = S_FETCH;
`ifdef ACC_OVF_FLAG_EN
            ovf_d   = 1'b0;
`endif
          end
        end
        S_FETCH: begin
          ir_op_d   = mem_rd[DATA_W-1 -: OP_W];
          ir_addr_d = mem_rd[ADDR_W-1:0];
          pc_d      = pc_q + 1'b1;
          state_d   = S_DECODE;
        end
        S_DECODE: begin
          case (ir_op_q)
            OP_LOAD:  state_d = S_LOAD;
            OP_STORE: state_d = S_STORE;
            OP_ADD:   state_d = S_ADD;
            OP_SUB:   state_d = S_SUB;
            OP_INPUT: begin
              state_d  = S_INPUT;
              clr_pend = 1'b1;
            end
            OP_JZ:    state_d = S_JZ;
            OP_JPOS:  state_d = S_JPOS;
            default:  state_d = S_HALT;
          endcase
        end
        S_LOAD: begin
          a_d     = mem_rd;
          state_d = S_FETCH;
        end
        S_STORE: begin
          mem_we    = 1'b1;
          mem_waddr = ir_addr_q;
          mem_wdata = a_q;
          state_d   = S_FETCH;
        end
        S_ADD: begin
          a_d     = add_res;
          state_d = S_FETCH;
`ifdef ACC_OVF_FLAG_EN
          if (add_ovf) ovf_d = 1'b1;
`endif
        end
        S_SUB: begin
          a_d     = sub_res;
          state_d = S_FETCH;
`ifdef ACC_OVF_FLAG_EN
          if (sub_ovf) ovf_d = 1'b1;
`endif
        end
        S_INPUT: begin
          if (pend_q) begin
            a_d      = Nin;
            clr_pend = 1'b1;
            state_d  = S_FETCH;
          end
        end
        S_JZ: begin
          if (Aeq0) pc_d = ir_addr_q;
          state_d = S_FETCH;
        end
        S_JPOS: begin
          if (Apos) pc_d = ir_addr_q;
          state_d = S_FETCH;
        end
        default: state_d = S_START;
      endcase
    end

    // A fresh press seen on this clock survives a concurrent clear.
    pend_d = clr_pend ? 1'b0 : pend_q;
    if (enter && !enter_q) pend_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_START;
      pc_q      <= '0;
      ir_op_q   <= '0;
      ir_addr_q <= '0;
      a_q       <= '0;
      nout_q    <= '0;
      enter_q   <= 1'b0;
      pend_q    <= 1'b0;
`ifdef ACC_OVF_FLAG_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_op_q   <= ir_op_d;
      ir_addr_q <= ir_addr_d;
      a_q       <= a_d;
      nout_q    <= nout_d;
      enter_q   <= enter;
      pend_q    <= pend_d;
`ifdef ACC_OVF_FLAG_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Write enable is masked by reset so no write lands while reset is held.
  acc_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clock   (clock),
    .we_i    (mem_we & reset),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rd)
  );

  assign Nout    = nout_q;
  assign Aeq0    = (a_q == '0);
  assign Apos    = !a_q[DATA_W-1] && (a_q != '0);
  assign halt    = (state_q == S_HALT);
  assign StateNo = state_q;
  assign pc      = pc_q;

endmodule

// File: doc/acc_cpu_param.md
Name: acc_cpu_param

Overview:
Parametrised accumulator-based processor core: control FSM, datapath and word memory in one block. Next generation of the team's 8-bit/5-bit-address accumulator CPU. Generalised data/address width. Adds a clock-enable step strobe in place of a divided clock, a program-load port, run/restart control and edge-detected enter handling. Sits under the board top, fed by switches/buttons; drives LEDs/7-seg.

Parameters:
DATA_W, 8, accumulator/memory word width; must be >= 3+ADDR_W
ADDR_W, 5, address width; memory depth = 2**ADDR_W words

Ports:
clock  in  1  system clock; all state on posedge
reset  in  1  asynchronous, active-low; clears all state
step_en  in  1  clock enable; FSM/datapath advance only on clock edges with step_en=1
run  in  1  level; start/restart execution from START or HALT
enter  in  1  operator button for INPUT instruction
Nin  in  DATA_W  operator input data
load_en  in  1  program-load write strobe
load_addr  in  ADDR_W  program-load address
load_data  in  DATA_W  program-load data
Nout  out  DATA_W  accumulator value, registered
Aeq0  out  1  A==0
Apos  out  1  A is positive: signed, nonzero, MSB=0
halt  out  1  high in HALT state
StateNo  out  4  current state encoding
pc  out  ADDR_W  program counter

Behaviour:
- Instruction word: opcode = bits[DATA_W-1:DATA_W-3]; address = bits[ADDR_W-1:0]; middle bits ignored.
- Opcodes:
  - 000 LOAD A<=M[a]
  - 001 STORE M[a]<=A
  - 010 ADD A<=A+M[a]
  - 011 SUB A<=A-M[a]
  - 100 INPUT A<=Nin on enter
  - 101 JZ: if Aeq0, PC<=a
  - 110 JPOS: if Apos, PC<=a
  - 111 HALT
- States (StateNo): START=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ADD=5, SUB=6, INPUT=7, JZ=8, JPOS=9, HALT=10. 11-15 unused; any unused value -> START.
- Reset: state=START, PC=0, IR=0, A=0, Nout=0, halt=0, enter pending=0. Memory contents undefined, not cleared.
- All transitions require step_en=1. With step_en=0, every register holds, except enter edge detect and load port, which run every clock.
- START: run=1 -> PC<=0, A<=0 -> FETCH.
- FETCH: IR<=M[PC], PC<=PC+1 (wraps 2**ADDR_W-1 -> 0) -> DECODE.
- DECODE: -> execute state per opcode. Entering INPUT clears enter pending.
- LOAD/STORE/ADD/SUB/JZ/JPOS: one step each -> FETCH. Untaken jump leaves PC.
- ADD/SUB: modulo 2**DATA_W, wrap silently.
- INPUT:
  - enter pending is set on a rising edge of enter (registered enter_q, every clock).
  - Stay in INPUT until pending=1 at a step, then A<=Nin, clear pending -> FETCH.
- HALT: halt=1. run=1 -> same as START (PC<=0, A<=0) -> FETCH.
- Memory: combinational read, synchronous write.
  - STORE write happens on the STORE step.
  - Load port writes only when state is START or HALT; ignored otherwise.
  - If STORE and load_en coincide, STORE wins (cannot occur by the rule above).
- Nout tracks A one step later at most (Nout<=A each step).
- Aeq0/Apos are combinational from A.
- Reset asserted mid-instruction: immediate return to reset values; no partial memory write after reset assertion.

Optional Feature:
Macro ACC_OVF_FLAG_EN.
- Defined: adds output ovf (1 bit). Set sticky on signed overflow of ADD/SUB. Cleared by reset or by run leaving START/HALT.
- Undefined: no ovf port; arithmetic is identical.

Decomposition:
- Shared package acc_cpu_pkg: opcode localparams (OP_LOAD..OP_HALT), state encoding constants (S_START..S_HALT, 4 bits), opcode field width 3.
- One sub-module acc_mem: parametrised DATA_W/ADDR_W register-array memory, async read, one sync write port. Top muxes STORE vs load port onto it.

Test Plan:
- Reset with state mid-FETCH -> StateNo=0, Nout=0, halt=0, pc=0 immediately (async).
- Load prog: M0=LOAD 10, M1=ADD 11, M2=STORE 12, M3=HALT; M10=5, M11=7. Then run, step_en=1 -> HALT reached, M12=12, Nout=12, halt=1.
- step_en toggled 1-of-4 cycles on the same program -> same final result; StateNo holds between strobes.
- INPUT program with enter pressed before INPUT reached -> press ignored. Then Nin=0x2A, enter pulse -> A=0x2A next step.
- JZ/JPOS loop: countdown from 3 with SUB 1 and JPOS to loop -> exactly 3 iterations, A=0. Aeq0=1, Apos=0 at exit.
- DATA_W=12, ADDR_W=8 build: 0x7FF+1 -> A=0x800, Apos=0. With ACC_OVF_FLAG_EN -> ovf=1. PC wrap 255->0 checked.
